ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Execute-stage RV32M multiply/divide unit, sitting directly downstream of the ID/EX pipeline register and consuming its ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data and ex_rd outputs. It detects M-extension instructions and computes them iteratively over multiple cycles. While it works it holds the front of the pipeline with a stall, then presents a one-cycle result pulse to the EX/MEM result mux.

## Interface
- CORE, 0, core index for multi-core builds; no functional effect.
- XLEN, 32, operand and result width.
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  ID/EX holds a valid (non-bubble) instruction.
- ex_flush  in  1  kill the current EX instruction (branch/JAL redirect).
- ex_opcode  in  7  instruction opcode.
- ex_funct3  in  3  selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (0..7).
- ex_funct7  in  7  0000001 marks an M-extension op.
- ex_rs1_data  in  XLEN  operand A.
- ex_rs2_data  in  XLEN  operand B.
- ex_rd  in  5  destination register.
- md_stall  out  1  freeze the PC, IF/ID and ID/EX registers this cycle.
- md_done  out  1  one-cycle pulse; md_result and md_rd are valid.
- md_result  out  XLEN  computed value.
- md_rd  out  5  destination register for md_result.

## Operation
- start = ex_valid & ~ex_flush & (ex_opcode == 0110011) & (ex_funct7 == 0000001) & (state == IDLE).
- The FSM has four states: IDLE, CALC, FIXUP and DONE.
- IDLE:
  - On start, latch funct3, rd and the operand magnitudes.
  - Record the sign flags:
    - signed ops are MULH, DIV and REM;
    - MULHSU treats rs1 as signed and rs2 as unsigned;
    - MUL ignores signs (low word is sign-agnostic).
  - Load cnt = 0.
  - Transition to CALC, except for special cases, which go directly to DONE.
- Special cases: the result is fixed in IDLE and CALC is skipped.
  - Divide by zero (rs2 == 0): DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC performs one iteration per cycle; cnt increments and goes to FIXUP after cnt == XLEN-1.
  - Multiply: shift-add over a 2·XLEN accumulator.
  - Divide: restoring shift-subtract over a remainder register of XLEN+1 bits and a quotient register of XLEN bits.
- FIXUP applies sign correction and selects the output:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ; the remainder takes the dividend's sign.
  - Select the low word for MUL, the high word for MULH*, the quotient for DIV*, the remainder for REM*.
- DONE: md_done = 1, md_result/md_rd are driven, md_stall = 0, then return to IDLE.
- Flush: ex_flush in any state forces IDLE next cycle.
  - No md_done is produced for the killed instruction.
  - A flush in the same cycle as a would-be start suppresses the start.
- Non-M instructions pass through: no stall and no done.

## Timing
- Reset values: state = IDLE, cnt = 0, md_done = 0, md_result = 0, md_rd = 0. md_stall is 0 while reset is high.
- md_stall = (state ∈ {CALC, FIXUP}) | start. It is combinational, so it is asserted in the same cycle the M-op appears in EX.
- md_result and md_rd are registered and hold their last value outside DONE.
- Normal latency, with the M-op arriving in EX at cycle 0:
  - cycle 0: IDLE with start;
  - cycles 1..32: CALC;
  - cycle 33: FIXUP;
  - cycle 34: DONE, with md_done = 1.
  - md_stall is high for cycles 0..33.
- Special cases: md_done at cycle 1; md_stall is high in cycle 0 only.
- In DONE the ID/EX register advances at the clock edge. The same instruction is therefore never restarted, because the FSM returns to IDLE on that edge.
- Reset mid-operation: IDLE on the next edge, and no done is produced.
- Back-to-back M-ops: the second one starts in the cycle after DONE.

## Configuration
- MULDIV_FAST_MUL_EN
  - Defined: MUL* ops compute the full signed 2·XLEN product in the IDLE cycle, register it, and go IDLE→DONE, so md_done arrives at cycle 1. Divide ops are unchanged.
  - Undefined: multiplies use the iterative CALC/FIXUP path with 34-cycle latency.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum (IDLE, CALC, FIXUP, DONE);
  - OPCODE_OP = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001;
  - funct3 constants F3_MUL..F3_REMU;
  - CNT_W = $clog2(XLEN).
- One sub-module, muldiv_iter_core, contains the per-cycle shift-add / shift-subtract datapath and the accumulator registers. The top level holds the FSM, the special-case detection, the sign fixup and the stall/done logic.

## Test plan
- MUL with rs1 = 7, rs2 = 6 → md_done at cycle 34 (cycle 1 with FAST_MUL), md_result = 42, md_rd = ex_rd; md_stall high cycles 0..33.
- MULH with rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU with rs1 = 0xFFFFFFFF, rs2 = 2 → 0xFFFFFFFF.
- DIV with rs1 = −7, rs2 = 2 → −3 (0xFFFFFFFD). REM with the same operands → −1. DIVU with rs1 = 100, rs2 = 7 → 14. REMU with the same operands → 2.
- DIVU with rs2 = 0, rs1 = 0x1234 → all ones, done at cycle 1. REM with rs2 = 0 → 0x1234. DIV with rs1 = 0x80000000, rs2 = −1 → 0x80000000, and REM with the same operands → 0.
- ex_flush at cycle 10 of a DIV → IDLE at cycle 11, md_done never pulses, md_stall low from cycle 11. A non-M ADD at cycle 11 → no stall.
- Reset asserted at cycle 20 of a MUL → all outputs return to their reset values. A following M-op then completes normally, and back-to-back M-ops give exactly one md_done each.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M execute-stage multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int CNT_W    = $clog2(XLEN_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage bundle between the ID/EX register, the mul/div unit and the EX/MEM result mux.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_flush;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [4:0]      md_rd;

    modport master (
        output ex_valid, ex_flush, ex_opcode, ex_funct3, ex_funct7,
               ex_rs1_data, ex_rs2_data, ex_rd,
        input  md_stall, md_done, md_result, md_rd
    );

    modport slave (
        input  ex_valid, ex_flush, ex_opcode, ex_funct3, ex_funct7,
               ex_rs1_data, ex_rs2_data, ex_rd,
        output md_stall, md_done, md_result, md_rd
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply and restoring divide, one bit per step.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [XLEN-1:0]   opA_i,
    input  logic [XLEN-1:0]   opB_i,
    output logic [2*XLEN-1:0] product_o,
    output logic [XLEN-1:0]   quotient_o,
    output logic [XLEN-1:0]   remainder_o
);
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   opB_q, opB_d;
    logic [XLEN:0]     partial;
    logic [XLEN+1:0]   shifted;
    logic [XLEN:0]     diff;

    // Both engines step together; the top picks whichever result the opcode wants.
    always_comb begin
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        opB_d   = opB_q;
        partial = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted[XLEN:0] - {1'b0, opB_q};
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, opA_i};
            rem_d = '0;
            quo_d = opA_i;
            opB_d = opB_i;
        end else if (step_i) begin
            acc_d = {partial, acc_q[XLEN-1:1]};
            if (shifted >= {2'b00, opB_q}) begin
                rem_d = diff;
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            opB_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            opB_q <= opB_d;
        end
    end

    assign product_o   = acc_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q[XLEN-1:0];
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: FSM, special cases, sign fixup, stall/done.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies, divides stay iterative.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int CORE = 0,
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    ex_muldiv_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CALC  = CALC;
    localparam logic [1:0] ST_FIXUP = FIXUP;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    if (XLEN != XLEN_DEF || CORE < 0) begin : gBadCfg
        $error("ex_muldiv_unit: counter width is sized for XLEN=32 and CORE must be >= 0");
    end

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d, mdRd_q, mdRd_d;
    logic              negA_q, negA_d, negB_q, negB_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              start, isDiv, signedA, signedB, negA, negB;
    logic              divByZero, overflow, special, fastPath;
    logic [XLEN-1:0]   rs1, rs2, magA, magB, specialResult, fixResult, fastResult;
    logic [2*XLEN-1:0] product, prodFix;
    logic [XLEN-1:0]   quotient, remainder;

    assign rs1   = bus.ex_rs1_data;
    assign rs2   = bus.ex_rs2_data;
    assign isDiv = bus.ex_funct3[2];
    assign start = bus.ex_valid & ~bus.ex_flush & (bus.ex_opcode == OPCODE_OP)
                 & (bus.ex_funct7 == FUNCT7_MULDIV) & (state_q == ST_IDLE);

    always_comb begin
        signedA = 1'b0;
        signedB = 1'b0;
        case (bus.ex_funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signedA = 1'b1;
                signedB = 1'b1;
            end
            F3_MULHSU: signedA = 1'b1;
            default: ;
        endcase
    end

    assign negA = signedA & rs1[XLEN-1];
    assign negB = signedB & rs2[XLEN-1];
    assign magA = negA ? -rs1 : rs1;
    assign magB = negB ? -rs2 : rs2;

    // funct3[1] separates REM* from DIV* for both special-case results.
    assign divByZero     = isDiv & (rs2 == '0);
    assign overflow      = isDiv & ~bus.ex_funct3[0] & (rs1 == MIN_VAL) & (rs2 == '1);
    assign special       = divByZero | overflow;
    assign specialResult = divByZero ? (bus.ex_funct3[1] ? rs1 : '1)
                                     : (bus.ex_funct3[1] ? '0 : MIN_VAL);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fastA, fastB;
    logic signed [2*XLEN+1:0] fastProd;
    assign fastA      = {signedA & rs1[XLEN-1], rs1};
    assign fastB      = {signedB & rs2[XLEN-1], rs2};
    assign fastProd   = fastA * fastB;
    assign fastPath   = ~isDiv;
    assign fastResult = (bus.ex_funct3 == F3_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
`else
    assign fastPath   = 1'b0;
    assign fastResult = '0;
`endif

    muldiv_iter_core #(.XLEN(XLEN)) uIterCore (
        .clock       (clock),
        .reset       (reset),
        .load_i      (start & ~special & ~fastPath),
        .step_i      (state_q == ST_CALC),
        .opA_i       (magA),
        .opB_i       (magB),
        .product_o   (product),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    assign prodFix = (negA_q ^ negB_q) ? -product : product;

    always_comb begin
        case (funct3_q)
            F3_MUL:                      fixResult = prodFix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixResult = prodFix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fixResult = (negA_q ^ negB_q) ? -quotient : quotient;
            default:                     fixResult = negA_q ? -remainder : remainder;
        endcase
    end

    // A flush kills whatever is in flight, including a result about to be published.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        negA_d   = negA_q;
        negB_d   = negB_q;
        result_d = result_q;
        mdRd_d   = mdRd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    funct3_d = bus.ex_funct3;
                    rd_d     = bus.ex_rd;
                    negA_d   = negA;
                    negB_d   = negB;
                    cnt_d    = '0;
                    if (special) begin
                        state_d  = ST_DONE;
                        result_d = specialResult;
                        mdRd_d   = bus.ex_rd;
                    end else if (fastPath) begin
                        state_d  = ST_DONE;
                        result_d = fastResult;
                        mdRd_d   = bus.ex_rd;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                state_d  = ST_DONE;
                result_d = fixResult;
                mdRd_d   = rd_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.ex_flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            mdRd_d   = mdRd_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            result_q <= '0;
            mdRd_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            negA_q   <= negA_d;
            negB_q   <= negB_d;
            result_q <= result_d;
            mdRd_q   <= mdRd_d;
        end
    end

    assign bus.md_stall  = ~reset & ((state_q == ST_CALC) | (state_q == ST_FIXUP) | start);
    assign bus.md_done   = (state_q == ST_DONE);
    assign bus.md_result = result_q;
    assign bus.md_rd     = mdRd_q;
endmodule
